// File: rtl/clk_div_multi_if.sv
// Bus bundle for clk_div_multi: per-channel control in, tick/divided-clock status out.
// The sync_clr member exists only when CLK_DIV_SYNC_EN is defined.
interface clk_div_multi_if #(
    parameter int CNT_W  = 32,
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH*CNT_W-1:0] div_val;
`ifdef CLK_DIV_SYNC_EN
    logic                    sync_clr;
`endif
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       new_clk;
    logic [NUM_CH-1:0]       cnt_busy;

`ifdef CLK_DIV_SYNC_EN
    modport master (
        output en, div_load, div_val, sync_clr,
        input  tick, new_clk, cnt_busy
    );

    modport slave (
        input  en, div_load, div_val, sync_clr,
        output tick, new_clk, cnt_busy
    );
`else
    modport master (
        output en, div_load, div_val,
        input  tick, new_clk, cnt_busy
    );

    modport slave (
        input  en, div_load, div_val,
        output tick, new_clk, cnt_busy
    );
`endif

endinterface : clk_div_multi_if

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable / 50%-duty divided-clock generator, one counter per channel.
// Optional CLK_DIV_SYNC_EN adds sync_clr, which phase-aligns every channel in one edge.
module clk_div_multi #(
    parameter int CNT_W   = 32,
    parameter int NUM_CH  = 4,
    parameter int DEF_DIV = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    clk_div_multi_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0]  div_r     [NUM_CH];
    logic [CNT_W-1:0]  cnt_r     [NUM_CH];
    logic [NUM_CH-1:0] tick_r;
    logic [NUM_CH-1:0] new_clk_r;

    logic [CNT_W-1:0]  last_s    [NUM_CH];
    logic [CNT_W-1:0]  div_nxt_s [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] tick_nxt_s;
    logic [NUM_CH-1:0] new_clk_nxt_s;
    logic [NUM_CH-1:0] busy_s;

    // Terminal count per channel; divisor 0 behaves as divisor 1.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (div_r[i] == CNT_ZERO) begin
                last_s[i] = CNT_ZERO;
            end else begin
                last_s[i] = div_r[i] - CNT_ONE;
            end
        end
    end

    // Next-state selection per channel: [sync_clr] > load > disable > terminal > count.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_nxt_s[i]     = div_r[i];
            cnt_nxt_s[i]     = cnt_r[i];
            tick_nxt_s[i]    = 1'b0;
            new_clk_nxt_s[i] = new_clk_r[i];
`ifdef CLK_DIV_SYNC_EN
            if (bus.sync_clr) begin
                cnt_nxt_s[i]     = CNT_ZERO;
                tick_nxt_s[i]    = 1'b0;
                new_clk_nxt_s[i] = 1'b0;
            end else
`endif
            if (bus.div_load[i]) begin
                div_nxt_s[i]  = bus.div_val[i*CNT_W +: CNT_W];
                cnt_nxt_s[i]  = CNT_ZERO;
                tick_nxt_s[i] = 1'b0;
            end else if (!bus.en[i]) begin
                cnt_nxt_s[i]  = cnt_r[i];
                tick_nxt_s[i] = 1'b0;
            end else if (cnt_r[i] == last_s[i]) begin
                cnt_nxt_s[i]     = CNT_ZERO;
                tick_nxt_s[i]    = 1'b1;
                new_clk_nxt_s[i] = ~new_clk_r[i];
            end else begin
                cnt_nxt_s[i]  = cnt_r[i] + CNT_ONE;
                tick_nxt_s[i] = 1'b0;
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_r[i] <= DIV_RST;
                cnt_r[i] <= CNT_ZERO;
            end
            tick_r    <= {NUM_CH{1'b0}};
            new_clk_r <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_r[i] <= div_nxt_s[i];
                cnt_r[i] <= cnt_nxt_s[i];
            end
            tick_r    <= tick_nxt_s;
            new_clk_r <= new_clk_nxt_s;
        end
    end

    // Busy flag decoded straight from the counter registers.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            busy_s[i] = (cnt_r[i] != CNT_ZERO);
        end
    end

    assign bus.tick     = tick_r;
    assign bus.new_clk  = new_clk_r;
    assign bus.cnt_busy = busy_s;

endmodule : clk_div_multi

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with DEF_DIV overridden to 5; sync_clr steps
// are included when CLK_DIV_SYNC_EN is defined.
module tb_clk_div_multi;

    localparam int CW = 32;
    localparam int NC = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    clk_div_multi_if #(.CNT_W(CW), .NUM_CH(NC)) dif ();

    clk_div_multi #(.CNT_W(CW), .NUM_CH(NC), .DEF_DIV(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset held low with enables and load strobes active
        reset        = 1'b0;
        dif.en       = 4'hF;
        dif.div_load = 4'hF;
        dif.div_val  = {4{32'd7}};
`ifdef CLK_DIV_SYNC_EN
        dif.sync_clr = 1'b0;
`endif
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_tick", dif.tick, 4'h0);
            check("rst_new_clk", dif.new_clk, 4'h0);
            check("rst_busy", dif.cnt_busy, 4'h0);
        end

        // Release: divisor must still be DEF_DIV=5 on every channel
        reset        = 1'b1;
        dif.div_load = 4'h0;
        for (int c = 1; c <= 15; c++) begin
            step();
            check("def_tick", dif.tick, (c % 5 == 0) ? 4'hF : 4'h0);
            check("def_new_clk", dif.new_clk, ((c / 5) % 2 == 1) ? 4'hF : 4'h0);
            check("def_busy", dif.cnt_busy, (c % 5 != 0) ? 4'hF : 4'h0);
        end

        // ch0 div=4 and ch1 div=3 loaded together; ch2/ch3 frozen
        dif.en                 = 4'b0011;
        dif.div_load           = 4'b0011;
        dif.div_val[0*CW +: CW] = 32'd4;
        dif.div_val[1*CW +: CW] = 32'd3;
        step();
        check("ld_tick", dif.tick, 4'h0);
        check("ld_new_clk_hold", dif.new_clk, 4'hF);
        dif.div_load = 4'h0;
        for (int c = 1; c <= 24; c++) begin
            step();
            check("d4_tick0", dif.tick[0], (c % 4 == 0) ? 1'b1 : 1'b0);
            check("d4_new_clk0", dif.new_clk[0], ((c / 4) % 2 == 0) ? 1'b1 : 1'b0);
            check("d3_tick1", dif.tick[1], (c % 3 == 0) ? 1'b1 : 1'b0);
            check("d3_new_clk1", dif.new_clk[1], ((c / 3) % 2 == 0) ? 1'b1 : 1'b0);
            check("frozen_tick", dif.tick[3:2], 2'b00);
            check("frozen_new_clk", dif.new_clk[3:2], 2'b11);
        end

        // ch2 with divisor 0, then divisor 1: tick every enabled cycle
        dif.en                 = 4'b0100;
        dif.div_load           = 4'b0100;
        dif.div_val[2*CW +: CW] = 32'd0;
        step();
        check("d0_ld_tick", dif.tick[2], 1'b0);
        check("d0_ld_new_clk", dif.new_clk[2], 1'b1);
        dif.div_load = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("d0_tick2", dif.tick[2], 1'b1);
            check("d0_new_clk2", dif.new_clk[2], (c % 2 == 0) ? 1'b1 : 1'b0);
            check("d0_busy2", dif.cnt_busy[2], 1'b0);
            check("d0_others", dif.tick[1:0], 2'b00);
        end
        dif.div_load           = 4'b0100;
        dif.div_val[2*CW +: CW] = 32'd1;
        step();
        check("d1_ld_tick", dif.tick[2], 1'b0);
        check("d1_ld_new_clk", dif.new_clk[2], 1'b1);
        dif.div_load = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("d1_tick2", dif.tick[2], 1'b1);
            check("d1_new_clk2", dif.new_clk[2], (c % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Reload mid-count: ch0 div=10, reload div=2 at count 6
        dif.en                 = 4'b0001;
        dif.div_load           = 4'b0001;
        dif.div_val[0*CW +: CW] = 32'd10;
        step();
        check("r10_busy", dif.cnt_busy[0], 1'b0);
        dif.div_load = 4'h0;
        for (int c = 1; c <= 6; c++) begin
            step();
            check("r10_tick0", dif.tick[0], 1'b0);
            check("r10_busy0", dif.cnt_busy[0], 1'b1);
        end
        dif.div_load           = 4'b0001;
        dif.div_val[0*CW +: CW] = 32'd2;
        step();
        check("r2_ld_tick0", dif.tick[0], 1'b0);
        check("r2_ld_new_clk0", dif.new_clk[0], 1'b1);
        check("r2_ld_busy0", dif.cnt_busy[0], 1'b0);
        dif.div_load = 4'h0;
        step();
        check("r2_c1_tick0", dif.tick[0], 1'b0);
        check("r2_c1_busy0", dif.cnt_busy[0], 1'b1);
        step();
        check("r2_c2_tick0", dif.tick[0], 1'b1);
        check("r2_c2_new_clk0", dif.new_clk[0], 1'b0);
        check("r2_c2_busy0", dif.cnt_busy[0], 1'b0);

        // Enable gap on ch1 div=5 at count 3
        dif.en                 = 4'b0010;
        dif.div_load           = 4'b0010;
        dif.div_val[1*CW +: CW] = 32'd5;
        step();
        dif.div_load = 4'h0;
        for (int c = 1; c <= 3; c++) begin
            step();
            check("gap_pre_tick1", dif.tick[1], 1'b0);
            check("gap_pre_busy1", dif.cnt_busy[1], 1'b1);
        end
        dif.en = 4'h0;
        for (int c = 1; c <= 7; c++) begin
            step();
            check("gap_tick1", dif.tick[1], 1'b0);
            check("gap_busy1", dif.cnt_busy[1], 1'b1);
            check("gap_new_clk1", dif.new_clk[1], 1'b1);
        end
        dif.en = 4'b0010;
        step();
        check("gap_r1_tick1", dif.tick[1], 1'b0);
        check("gap_r1_busy1", dif.cnt_busy[1], 1'b1);
        step();
        check("gap_r2_tick1", dif.tick[1], 1'b1);
        check("gap_r2_new_clk1", dif.new_clk[1], 1'b0);
        check("gap_r2_busy1", dif.cnt_busy[1], 1'b0);

`ifdef CLK_DIV_SYNC_EN
        // Misalign ch0 (div 2) and ch1 (div 3), then phase-align with sync_clr
        dif.en                 = 4'b0011;
        dif.div_load           = 4'b0011;
        dif.div_val[0*CW +: CW] = 32'd2;
        dif.div_val[1*CW +: CW] = 32'd3;
        step();
        dif.div_load = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            step();
        end
        dif.sync_clr = 1'b1;
        step();
        dif.sync_clr = 1'b0;
        check("sync_new_clk", dif.new_clk, 4'h0);
        check("sync_busy", dif.cnt_busy, 4'h0);
        check("sync_tick", dif.tick, 4'h0);
        for (int c = 1; c <= 6; c++) begin
            step();
            check("sync_tick0", dif.tick[0], (c % 2 == 0) ? 1'b1 : 1'b0);
            check("sync_tick1", dif.tick[1], (c % 3 == 0) ? 1'b1 : 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_clk_div_multi
